// File: rtl/board_engine.sv
// Playfield store for a falling-block game: piece locking, full-row detection,
// row collapse, spawn-zone blocking and a display read port.
//
// Ports:
//   clk, reset (async, active low), board_clear (sync clear)
//   lock_valid/lock_ready/lock_row/lock_rows : piece-lock handshake
//   spawnBlock, lineBreakMode                : inputs from game control FSM
//   fell, lineBreak, gameOver                : status back to game control
//   rd_row/rd_data                           : combinational display read
//   lines_cleared                            : saturating cleared-row count
module board_engine #(
   parameter int ROWS = 20,
   parameter int COLS = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              board_clear,
   input  logic              lock_valid,
   output logic              lock_ready,
   input  logic [4:0]        lock_row,
   input  logic [4*COLS-1:0] lock_rows,
   input  logic              spawnBlock,
   input  logic              lineBreakMode,
   output logic              fell,
   output logic              lineBreak,
   output logic              gameOver,
   input  logic [4:0]        rd_row,
   output logic [COLS-1:0]   rd_data,
   output logic [15:0]       lines_cleared
);

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      BREAK_WAIT,
      SHIFT,
      FELL
   } state_t;

   state_t            state_q, state_d;
   logic [COLS-1:0]   board_q [ROWS];
   logic [COLS-1:0]   board_d [ROWS];
   logic [4:0]        idx_q, idx_d;
   logic [4:0]        clr_q, clr_d;
   logic [15:0]       lines_q, lines_d;
   logic              go_q, go_d;
   logic              spawn_q;

   logic [COLS-1:0]   idx_row;
   logic              spawn_rise;
   logic              blocked;

   // Row under the scan pointer
   always_comb begin
      idx_row = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (idx_q == 5'(r)) idx_row = board_q[r];
      end
   end

   always_comb begin
      rd_data = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (rd_row == 5'(r)) rd_data = board_q[r];
      end
   end

   // Spawn zone is columns 3..6 of the top two rows
   assign spawn_rise = spawnBlock & ~spawn_q;
   assign blocked    = (|board_q[0][6:3]) | (|board_q[1][6:3]);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      clr_d   = clr_q;
      lines_d = lines_q;
      go_d    = go_q;
      board_d = board_q;

      case (state_q)
         IDLE: begin
            if (lock_valid && !go_q) begin
               // Piece rows landing past the bottom never match a row
               for (int i = 0; i < 4; i++) begin
                  for (int r = 0; r < ROWS; r++) begin
                     if (({1'b0, lock_row} + 6'(i)) == 6'(r)) begin
                        board_d[r] = board_d[r] | lock_rows[COLS*i +: COLS];
                     end
                  end
               end
               state_d = SCAN;
               idx_d   = 5'(ROWS-1);
            end
            if (spawn_rise && blocked) go_d = 1'b1;
         end
         SCAN: begin
            if (&idx_row) begin
               state_d = BREAK_WAIT;
               clr_d   = idx_q;
            end else if (idx_q == 5'd0) begin
               state_d = FELL;
            end else begin
               idx_d = idx_q - 5'd1;
            end
         end
         BREAK_WAIT: begin
            if (lineBreakMode) begin
               state_d = SHIFT;
               idx_d   = clr_q;
               if (lines_q != 16'hFFFF) lines_d = lines_q + 16'd1;
            end
         end
         SHIFT: begin
            for (int r = 1; r < ROWS; r++) begin
               if (idx_q == 5'(r)) board_d[r] = board_q[r-1];
            end
            if (idx_q == 5'd0) begin
               board_d[0] = '0;
               // Rescan the cleared row: the row dropped into it may be full
               state_d    = SCAN;
               idx_d      = clr_q;
            end else begin
               idx_d = idx_q - 5'd1;
            end
         end
         FELL: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (board_clear) begin
         state_d = IDLE;
         idx_d   = '0;
         clr_d   = '0;
         lines_d = '0;
         go_d    = 1'b0;
         for (int r = 0; r < ROWS; r++) board_d[r] = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         clr_q   <= '0;
         lines_q <= '0;
         go_q    <= 1'b0;
         spawn_q <= 1'b0;
         for (int r = 0; r < ROWS; r++) board_q[r] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         clr_q   <= clr_d;
         lines_q <= lines_d;
         go_q    <= go_d;
         spawn_q <= spawnBlock;
         for (int r = 0; r < ROWS; r++) board_q[r] <= board_d[r];
      end
   end

   assign lock_ready    = (state_q == IDLE) && !go_q;
   assign fell          = (state_q == FELL) && !go_q;
   assign lineBreak     = (state_q == BREAK_WAIT);
   assign gameOver      = go_q;
   assign lines_cleared = lines_q;

endmodule

// File: tb/tb_board_engine.sv
// Directed self-checking bench for board_engine.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_board_engine;

   localparam int ROWS = 20;
   localparam int COLS = 10;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              board_clear = 1'b0;
   logic              lock_valid = 1'b0;
   logic              lock_ready;
   logic [4:0]        lock_row = '0;
   logic [4*COLS-1:0] lock_rows = '0;
   logic              spawnBlock = 1'b0;
   logic              lineBreakMode = 1'b0;
   logic              fell;
   logic              lineBreak;
   logic              gameOver;
   logic [4:0]        rd_row = '0;
   logic [COLS-1:0]   rd_data;
   logic [15:0]       lines_cleared;

   int checks = 0;
   int errors = 0;

   board_engine #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk(clk), .reset(reset), .board_clear(board_clear),
      .lock_valid(lock_valid), .lock_ready(lock_ready),
      .lock_row(lock_row), .lock_rows(lock_rows),
      .spawnBlock(spawnBlock), .lineBreakMode(lineBreakMode),
      .fell(fell), .lineBreak(lineBreak), .gameOver(gameOver),
      .rd_row(rd_row), .rd_data(rd_data),
      .lines_cleared(lines_cleared)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic read_row(input int r, output logic [COLS-1:0] v);
      rd_row = 5'(r);
      #1;
      v = rd_data;
   endtask

   task automatic count_nonzero(output int nz);
      logic [COLS-1:0] v;
      nz = 0;
      for (int r = 0; r < ROWS; r++) begin
         read_row(r, v);
         if (v !== '0) nz++;
      end
   endtask

   task automatic do_lock(input int row, input logic [4*COLS-1:0] rows,
                          output logic rdy);
      lock_row   = 5'(row);
      lock_rows  = rows;
      lock_valid = 1'b1;
      rdy        = lock_ready;
      tick();
      lock_valid = 1'b0;
      lock_rows  = '0;
   endtask

   // Grants every lineBreak, stops on the fell cycle or when budget expires
   task automatic run_to_fell(input int budget, output int cyc,
                              output int grants, output int both,
                              output logic tmo);
      cyc = 0; grants = 0; both = 0; tmo = 1'b0;
      while (fell !== 1'b1) begin
         if (cyc >= budget) begin
            tmo = 1'b1;
            break;
         end
         if (lineBreak === 1'b1) begin
            grants++;
            lineBreakMode = 1'b1;
            tick();
            lineBreakMode = 1'b0;
         end else begin
            tick();
         end
         cyc++;
         if (fell === 1'b1 && lineBreak === 1'b1) both++;
      end
   endtask

   task automatic quiet(input int n, output int fells, output int lbs);
      fells = 0; lbs = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (fell === 1'b1) fells++;
         if (lineBreak === 1'b1) lbs++;
      end
   endtask

   task automatic settle(input int row, input logic [4*COLS-1:0] rows);
      logic rdy, tmo;
      int c, g, b;
      do_lock(row, rows, rdy);
      run_to_fell(300, c, g, b, tmo);
      tick();
   endtask

   task automatic clear_board();
      board_clear = 1'b1;
      tick();
      board_clear = 1'b0;
   endtask

   task automatic test_reset();
      logic [COLS-1:0] v;
      int nz;
      reset = 1'b0;
      tick(); tick();
      checks++;
      if (fell !== 1'b0 || lineBreak !== 1'b0 || gameOver !== 1'b0) begin
         errors++;
         $display("FAIL rst_flags got fell=%b lb=%b go=%b want 000",
                  fell, lineBreak, gameOver);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (lock_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_ready got %b want 1", lock_ready);
      end
      checks++;
      if (lines_cleared !== 16'd0) begin
         errors++;
         $display("FAIL rst_lines got %0d want 0", lines_cleared);
      end
      count_nonzero(nz);
      checks++;
      if (nz != 0) begin
         errors++;
         $display("FAIL rst_board got %0d nonzero rows want 0", nz);
      end
      read_row(25, v);
      checks++;
      if (v !== '0) begin
         errors++;
         $display("FAIL rd_oob got %h want 0", v);
      end
   endtask

   task automatic test_lock_latency();
      logic rdy, tmo;
      logic [COLS-1:0] v;
      int c, g, b, f, l;
      do_lock(18, 40'h00F, rdy);
      checks++;
      if (rdy !== 1'b1) begin
         errors++;
         $display("FAIL lat_accept got %b want 1", rdy);
      end
      checks++;
      if (lock_ready !== 1'b0) begin
         errors++;
         $display("FAIL lat_busy got %b want 0", lock_ready);
      end
      // Lock and grant requests while scanning must be ignored
      lock_row = 5'd5; lock_rows = 40'h111; lock_valid = 1'b1;
      lineBreakMode = 1'b1;
      tick(); tick();
      lock_valid = 1'b0; lock_rows = '0; lineBreakMode = 1'b0;
      run_to_fell(100, c, g, b, tmo);
      checks++;
      if (tmo || c != 18 || g != 0) begin
         errors++;
         $display("FAIL lat_fell got cyc=%0d grants=%0d tmo=%b want 18/0/0",
                  c, g, tmo);
      end
      tick();
      checks++;
      if (fell !== 1'b0 || lock_ready !== 1'b1) begin
         errors++;
         $display("FAIL lat_pulse got fell=%b rdy=%b want 0/1",
                  fell, lock_ready);
      end
      read_row(18, v);
      checks++;
      if (v !== 10'h00F) begin
         errors++;
         $display("FAIL lat_row18 got %h want 00f", v);
      end
      read_row(5, v);
      checks++;
      if (v !== 10'h000) begin
         errors++;
         $display("FAIL lat_ignored got %h want 000", v);
      end
      quiet(5, f, l);
   endtask

   task automatic test_back_to_back();
      logic rdy, tmo;
      logic [COLS-1:0] v;
      int c, g, b;
      clear_board();
      do_lock(19, 40'h001, rdy);
      run_to_fell(100, c, g, b, tmo);
      tick();
      do_lock(19, 40'h002, rdy);
      checks++;
      if (rdy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept got %b want 1", rdy);
      end
      run_to_fell(100, c, g, b, tmo);
      checks++;
      if (tmo || c != 20) begin
         errors++;
         $display("FAIL b2b_lat got %0d tmo=%b want 20", c, tmo);
      end
      read_row(19, v);
      checks++;
      if (v !== 10'h003) begin
         errors++;
         $display("FAIL b2b_row19 got %h want 003", v);
      end
      tick();
   endtask

   task automatic test_line_break();
      logic rdy, tmo;
      logic [COLS-1:0] v;
      int c, g, b, w;
      clear_board();
      settle(18, 40'h00000FC0A5);
      do_lock(19, 40'h00F, rdy);
      w = 0;
      while (lineBreak !== 1'b1 && w < 30) begin
         tick();
         w++;
      end
      checks++;
      if (w != 1 || fell !== 1'b0) begin
         errors++;
         $display("FAIL lb_assert got wait=%0d fell=%b want 1/0", w, fell);
      end
      tick(); tick();
      checks++;
      if (lineBreak !== 1'b1 || lines_cleared !== 16'd0) begin
         errors++;
         $display("FAIL lb_hold got lb=%b lines=%0d want 1/0",
                  lineBreak, lines_cleared);
      end
      lineBreakMode = 1'b1;
      tick();
      lineBreakMode = 1'b0;
      checks++;
      if (lineBreak !== 1'b0 || lines_cleared !== 16'd1) begin
         errors++;
         $display("FAIL lb_grant got lb=%b lines=%0d want 0/1",
                  lineBreak, lines_cleared);
      end
      run_to_fell(100, c, g, b, tmo);
      checks++;
      if (tmo || g != 0) begin
         errors++;
         $display("FAIL lb_fell got grants=%0d tmo=%b want 0/0", g, tmo);
      end
      read_row(19, v);
      checks++;
      if (v !== 10'h0A5) begin
         errors++;
         $display("FAIL lb_row19 got %h want 0a5", v);
      end
      read_row(18, v);
      checks++;
      if (v !== 10'h000) begin
         errors++;
         $display("FAIL lb_row18 got %h want 000", v);
      end
      tick();
   endtask

   task automatic test_double_clear();
      logic rdy, tmo;
      logic [COLS-1:0] v;
      int c, g, b, f, l;
      clear_board();
      settle(17, 40'h0000FFC123);
      do_lock(18, 40'h00000FC00F, rdy);
      run_to_fell(300, c, g, b, tmo);
      checks++;
      if (tmo || g != 2 || b != 0) begin
         errors++;
         $display("FAIL dbl_grants got %0d both=%0d tmo=%b want 2/0/0",
                  g, b, tmo);
      end
      checks++;
      if (lines_cleared !== 16'd2) begin
         errors++;
         $display("FAIL dbl_lines got %0d want 2", lines_cleared);
      end
      read_row(19, v);
      checks++;
      if (v !== 10'h123) begin
         errors++;
         $display("FAIL dbl_row19 got %h want 123", v);
      end
      quiet(30, f, l);
      checks++;
      if (f != 0 || l != 0) begin
         errors++;
         $display("FAIL dbl_single got fell=%0d lb=%0d want 0/0", f, l);
      end
   endtask

   task automatic test_discard();
      logic rdy, tmo;
      logic [COLS-1:0] v;
      int c, g, b, nz;
      clear_board();
      settle(17, 40'h055);
      do_lock(18, 40'hFF_FFFF_FFFF, rdy);
      run_to_fell(300, c, g, b, tmo);
      checks++;
      if (tmo || g != 2 || lines_cleared !== 16'd2) begin
         errors++;
         $display("FAIL disc_lines got grants=%0d lines=%0d tmo=%b want 2/2/0",
                  g, lines_cleared, tmo);
      end
      read_row(19, v);
      checks++;
      if (v !== 10'h055) begin
         errors++;
         $display("FAIL disc_row19 got %h want 055", v);
      end
      count_nonzero(nz);
      checks++;
      if (nz != 1) begin
         errors++;
         $display("FAIL disc_rows got %0d nonzero want 1", nz);
      end
      tick();
   endtask

   task automatic test_spawn();
      logic [COLS-1:0] v;
      int f, l, nz;
      clear_board();
      settle(0, 40'h084);
      spawnBlock = 1'b1;
      tick(); tick();
      spawnBlock = 1'b0;
      tick();
      checks++;
      if (gameOver !== 1'b0) begin
         errors++;
         $display("FAIL spawn_clear got %b want 0", gameOver);
      end
      settle(1, 40'h008);
      spawnBlock = 1'b1;
      tick();
      checks++;
      if (gameOver !== 1'b1) begin
         errors++;
         $display("FAIL spawn_set got %b want 1", gameOver);
      end
      tick();
      spawnBlock = 1'b0;
      tick();
      checks++;
      if (gameOver !== 1'b1 || lock_ready !== 1'b0) begin
         errors++;
         $display("FAIL spawn_sticky got go=%b rdy=%b want 1/0",
                  gameOver, lock_ready);
      end
      lock_row = 5'd10; lock_rows = 40'h3FF; lock_valid = 1'b1;
      quiet(25, f, l);
      lock_valid = 1'b0; lock_rows = '0;
      read_row(10, v);
      checks++;
      if (f != 0 || l != 0 || v !== 10'h000) begin
         errors++;
         $display("FAIL spawn_nolock got fell=%0d lb=%0d row10=%h want 0/0/000",
                  f, l, v);
      end
      clear_board();
      count_nonzero(nz);
      checks++;
      if (gameOver !== 1'b0 || nz != 0 || lock_ready !== 1'b1) begin
         errors++;
         $display("FAIL spawn_bclr got go=%b nz=%0d rdy=%b want 0/0/1",
                  gameOver, nz, lock_ready);
      end
   endtask

   task automatic test_clear_abort();
      logic rdy;
      int f, l, nz;
      clear_board();
      settle(19, 40'h3F0);
      do_lock(19, 40'h00F, rdy);
      tick();
      board_clear = 1'b1;
      tick();
      board_clear = 1'b0;
      checks++;
      if (lineBreak !== 1'b0 || lock_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_state got lb=%b rdy=%b want 0/1",
                  lineBreak, lock_ready);
      end
      quiet(30, f, l);
      count_nonzero(nz);
      checks++;
      if (f != 0 || l != 0 || nz != 0) begin
         errors++;
         $display("FAIL abort_quiet got fell=%0d lb=%0d nz=%0d want 0/0/0",
                  f, l, nz);
      end
   endtask

   task automatic test_reset_mid();
      logic rdy;
      logic [COLS-1:0] v;
      int f, l;
      settle(19, 40'h3F0);
      do_lock(19, 40'h00F, rdy);
      tick();
      checks++;
      if (lineBreak !== 1'b1) begin
         errors++;
         $display("FAIL rmid_pre got %b want 1", lineBreak);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (lineBreak !== 1'b0) begin
         errors++;
         $display("FAIL rmid_async got %b want 0", lineBreak);
      end
      read_row(19, v);
      checks++;
      if (v !== 10'h000) begin
         errors++;
         $display("FAIL rmid_board got %h want 000", v);
      end
      tick();
      reset = 1'b1;
      quiet(30, f, l);
      checks++;
      if (f != 0 || l != 0 || lock_ready !== 1'b1) begin
         errors++;
         $display("FAIL rmid_after got fell=%0d lb=%0d rdy=%b want 0/0/1",
                  f, l, lock_ready);
      end
   endtask

   initial begin
      test_reset();
      test_lock_latency();
      test_back_to_back();
      test_line_break();
      test_double_clear();
      test_discard();
      test_spawn();
      test_clear_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/board_engine.md
BOARD_ENGINE -- requirements
Module: board_engine

Interface
REQ-001 Parameter ROWS, default 20: board height; row 0 is the top row, row ROWS-1 the bottom row.
REQ-002 Parameter COLS, default 10: board width; bit c of a row word is column c.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 board_clear  in  1  synchronous clear of the board, counter and gameOver.
REQ-006 lock_valid  in  1  piece-lock request.
REQ-007 lock_ready  out  1  lock accepted when lock_valid&&lock_ready.
REQ-008 lock_row  in  5  board row receiving the top piece row.
REQ-009 lock_rows  in  4*COLS  piece rows; bits [COLS*i+COLS-1:COLS*i] OR into row lock_row+i.
REQ-010 spawnBlock  in  1  spawn indication from the game control FSM.
REQ-011 lineBreakMode  in  1  line-break grant from the game control FSM.
REQ-012 fell  out  1  one-cycle pulse: lock fully processed, new piece required.
REQ-013 lineBreak  out  1  level: full row pending, awaiting grant.
REQ-014 gameOver  out  1  sticky: spawn zone blocked.
REQ-015 rd_row  in  5  display read address.
REQ-016 rd_data  out  COLS  combinational board[rd_row]; 0 when rd_row>=ROWS.
REQ-017 lines_cleared  out  16  saturating count of cleared rows.

Function
REQ-018 States IDLE, SCAN, BREAK_WAIT, SHIFT, FELL; lock_ready=1 only in IDLE with gameOver=0.
REQ-019 Lock accepted at cycle T: rows lock_row+i (i=0..3) OR-updated at T+1, state SCAN at T+1 with scan index ROWS-1; piece rows with lock_row+i>=ROWS discarded.
REQ-020 SCAN checks one row per cycle, index decrementing; row all-ones -> BREAK_WAIT with clr_row latched; after row 0 checked not full -> FELL.
REQ-021 No full rows: lock at T, fell=1 at exactly T+ROWS+1 (T+21 default) for one cycle, then IDLE.
REQ-022 lineBreak=1 for every cycle in BREAK_WAIT; fell and lineBreak never both 1.
REQ-023 BREAK_WAIT + lineBreakMode=1 -> SHIFT with shift index clr_row; lines_cleared increments on that transition, saturating at 16'hFFFF.
REQ-024 SHIFT: each cycle board[idx] <= board[idx-1] (board[0] <= 0), idx decrements; after idx 0 written -> SCAN restarting at clr_row.
REQ-025 lineBreakMode outside BREAK_WAIT ignored; lock_valid outside IDLE ignored, no pending capture.
REQ-026 Spawn check: first cycle of spawnBlock high (rising edge vs. registered copy) in IDLE; any bit [6:3] set in rows 0 or 1 -> gameOver=1 next cycle.
REQ-027 gameOver remains 1 until board_clear or reset; fell not asserted while gameOver=1.
REQ-028 board_clear highest priority: next cycle board all 0, lines_cleared 0, gameOver 0, state IDLE, fell/lineBreak 0.
REQ-029 board_clear mid-SCAN/BREAK_WAIT/SHIFT aborts the operation with no fell pulse.

Reset
REQ-030 reset low asynchronously forces: board all 0, state IDLE, lines_cleared 0, gameOver 0, fell 0, lineBreak 0, spawnBlock edge register 0; lock_ready 1 after reset release.
REQ-031 reset asserted mid-operation discards the operation; no fell or lineBreak after release until a new lock.

Verification
REQ-032 Empty board, lock row 18 rows {0x00F,0,0,0} -> fell pulse exactly 21 cycles after accept, board[18]=0x00F, lineBreak never 1.
REQ-033 board[19]=0x3F0 preloaded, lock row 19 lock_rows[9:0]=0x00F -> lineBreak=1; grant lineBreakMode one cycle -> board[19]=prior board[18], board[0]=0, lines_cleared=1, then fell pulse.
REQ-034 Rows 18,19 completed by one lock -> two lineBreak/grant cycles, lines_cleared=2, single fell pulse at end.
REQ-035 board[1]=0x008, spawnBlock high 2 cycles -> gameOver=1 one cycle after first high, stays 1; lock_ready=0; board_clear -> gameOver=0, board 0.
REQ-036 lock_row=18 with 4 rows all 0x3FF -> rows 20/21 discarded, rows 18,19 cleared, lines_cleared=2.
REQ-037 reset pulsed low during BREAK_WAIT -> lineBreak=0 immediately, board 0, no fell after release.
